// File: rtl/riscv_alu_exec.sv
// -----------------------------------------------------------------------------
// riscv_alu_exec
//
// Registered execute-stage slice of a small RISC-V-style core.
// Each accepted operation passes through three combinational stages:
//    1. Main control decode: opcode to datapath controls and the ALU-op class.
//    2. ALU-control decode: ALU-op class plus function bits to an ALU opcode.
//    3. ALU: operand A combined with either op_b or imm.
// All results and controls are registered together, so latency is one cycle.
//
// Ports:
//    clk         : clock, rising edge
//    rst_n       : asynchronous active-low reset, clears every output
//    in_valid    : operation present this cycle
//    opcode      : instruction[6:0]
//    funct_bits  : {instruction[30], instruction[14:12]}
//    op_a, op_b  : register-file read values (rs1, rs2)
//    imm         : sign-extended immediate
//    out_valid   : registered result valid (one cycle after in_valid)
//    result      : registered ALU result
//    zero        : registered flag, 1 when result == 0
//    alu_src, mem_reg, reg_write, mem_read, mem_write, branch : registered controls
//    alu_op      : registered ALU-op class
//    alu_ctrl    : registered ALU opcode
// -----------------------------------------------------------------------------
module riscv_alu_exec #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [6:0]       opcode,
   input  logic [3:0]       funct_bits,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] imm,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             alu_src,
   output logic             mem_reg,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             branch,
   output logic [1:0]       alu_op,
   output logic [3:0]       alu_ctrl
);

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // ---------------------------------------------------------------- decode
   logic             alu_src_next;
   logic             mem_reg_next;
   logic             reg_write_next;
   logic             mem_read_next;
   logic             mem_write_next;
   logic             branch_next;
   logic [1:0]       alu_op_next;
   logic [3:0]       alu_ctrl_next;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] result_next;
   logic             zero_next;

   always_comb begin
      alu_src_next   = 1'b0;
      mem_reg_next   = 1'b0;
      reg_write_next = 1'b0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      branch_next    = 1'b0;
      alu_op_next    = 2'b00;
      case (opcode)
         OPC_RTYPE: begin
            reg_write_next = 1'b1;
            alu_op_next    = 2'b10;
         end
         OPC_LOAD: begin
            alu_src_next   = 1'b1;
            mem_reg_next   = 1'b1;
            reg_write_next = 1'b1;
            mem_read_next  = 1'b1;
         end
         OPC_STORE: begin
            alu_src_next   = 1'b1;
            mem_write_next = 1'b1;
         end
         OPC_BRANCH: begin
            branch_next    = 1'b1;
            alu_op_next    = 2'b01;
         end
         default: ;  // unknown opcode: all controls inactive, ALU adds
      endcase
   end

   always_comb begin
      alu_ctrl_next = ALU_ADD;
      case (alu_op_next)
         2'b01: alu_ctrl_next = ALU_SUB;
         2'b10: begin
            case (funct_bits)
               4'b0000: alu_ctrl_next = ALU_ADD;
               4'b1000: alu_ctrl_next = ALU_SUB;
               4'b0111: alu_ctrl_next = ALU_AND;
               4'b0110: alu_ctrl_next = ALU_OR;
               default: alu_ctrl_next = ALU_ADD;
            endcase
         end
         default: alu_ctrl_next = ALU_ADD;  // 00 and the unused 11 class
      endcase
   end

   // ------------------------------------------------------------------- ALU
   assign alu_b = alu_src_next ? imm : op_b;

   always_comb begin
      result_next = '0;
      case (alu_ctrl_next)
         ALU_AND: result_next = op_a & alu_b;
         ALU_OR:  result_next = op_a | alu_b;
         ALU_ADD: result_next = op_a + alu_b;  // carry out dropped
         ALU_SUB: result_next = op_a - alu_b;  // two's-complement wrap
         ALU_NOR: result_next = ~(op_a | alu_b);
         default: result_next = '0;
      endcase
   end

   // Derived before the register so zero always matches result.
   assign zero_next = (result_next == '0);

   // ------------------------------------------------------- output registers
   logic             out_valid_reg;
   logic [WIDTH-1:0] result_reg;
   logic             zero_reg;
   logic             alu_src_reg;
   logic             mem_reg_reg;
   logic             reg_write_reg;
   logic             mem_read_reg;
   logic             mem_write_reg;
   logic             branch_reg;
   logic [1:0]       alu_op_reg;
   logic [3:0]       alu_ctrl_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         zero_reg      <= 1'b0;
         alu_src_reg   <= 1'b0;
         mem_reg_reg   <= 1'b0;
         reg_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         branch_reg    <= 1'b0;
         alu_op_reg    <= 2'b00;
         alu_ctrl_reg  <= 4'b0000;
      end else begin
         out_valid_reg <= in_valid;
         // Idle cycles keep the last accepted operation visible.
         if (in_valid) begin
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            alu_src_reg   <= alu_src_next;
            mem_reg_reg   <= mem_reg_next;
            reg_write_reg <= reg_write_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            branch_reg    <= branch_next;
            alu_op_reg    <= alu_op_next;
            alu_ctrl_reg  <= alu_ctrl_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign zero      = zero_reg;
   assign alu_src   = alu_src_reg;
   assign mem_reg   = mem_reg_reg;
   assign reg_write = reg_write_reg;
   assign mem_read  = mem_read_reg;
   assign mem_write = mem_write_reg;
   assign branch    = branch_reg;
   assign alu_op    = alu_op_reg;
   assign alu_ctrl  = alu_ctrl_reg;

endmodule

// File: tb/tb_riscv_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_riscv_alu_exec
//
// Directed scenarios followed by randomized operations, each checked against
// a behavioural model built from the decode tables and plain arithmetic.
// -----------------------------------------------------------------------------
module tb_riscv_alu_exec;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [6:0]       opcode;
   logic [3:0]       funct_bits;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] imm;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             alu_src;
   logic             mem_reg;
   logic             reg_write;
   logic             mem_read;
   logic             mem_write;
   logic             branch;
   logic [1:0]       alu_op;
   logic [3:0]       alu_ctrl;

   riscv_alu_exec #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .opcode     (opcode),
      .funct_bits (funct_bits),
      .op_a       (op_a),
      .op_b       (op_b),
      .imm        (imm),
      .out_valid  (out_valid),
      .result     (result),
      .zero       (zero),
      .alu_src    (alu_src),
      .mem_reg    (mem_reg),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .branch     (branch),
      .alu_op     (alu_op),
      .alu_ctrl   (alu_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected registered state. ctrl is {alu_src,mem_reg,reg_write,mem_read,mem_write,branch,alu_op}.
   logic             exp_valid;
   logic [WIDTH-1:0] exp_result;
   logic             exp_zero;
   logic [7:0]       exp_ctrl;
   logic [3:0]       exp_alu_ctrl;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Main decode table from the opcode list.
   function automatic logic [7:0] model_ctrl(input logic [6:0] opc);
      logic [7:0] c;
      c = 8'b0;
      if (opc == 7'b0110011) c = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10};
      if (opc == 7'b0000011) c = {1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00};
      if (opc == 7'b0100011) c = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00};
      if (opc == 7'b1100011) c = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01};
      return c;
   endfunction

   function automatic logic [3:0] model_alu_ctrl(input logic [1:0] aop, input logic [3:0] fb);
      if (aop == 2'b01) return 4'b0110;
      if (aop != 2'b10) return 4'b0010;
      if (fb == 4'b1000) return 4'b0110;
      if (fb == 4'b0111) return 4'b0000;
      if (fb == 4'b0110) return 4'b0001;
      return 4'b0010;
   endfunction

   function automatic logic [WIDTH-1:0] model_alu(input logic [3:0] ac, input int unsigned a, input int unsigned b);
      int unsigned modulus;
      modulus = 1 << WIDTH;
      case (ac)
         4'b0000: return WIDTH'(a & b);
         4'b0001: return WIDTH'(a | b);
         4'b0010: return WIDTH'((a + b) % modulus);
         4'b0110: return WIDTH'((a + modulus - b) % modulus);
         4'b1100: return WIDTH'(~(a | b));
         default: return '0;
      endcase
   endfunction

   task automatic compare_all(input string tag);
      check_val({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
      check_val({tag, ".result"},    32'(result),    32'(exp_result));
      check_val({tag, ".zero"},      32'(zero),      32'(exp_zero));
      check_val({tag, ".ctrl"},
                32'({alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op}),
                32'(exp_ctrl));
      check_val({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'(exp_alu_ctrl));
   endtask

   // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
   task automatic step(input string tag, input logic v, input logic [6:0] opc, input logic [3:0] fb,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] im);
      logic [7:0]       c;
      logic [3:0]       ac;
      logic [WIDTH-1:0] r;
      @(negedge clk);
      in_valid   = v;
      opcode     = opc;
      funct_bits = fb;
      op_a       = a;
      op_b       = b;
      imm        = im;
      c  = model_ctrl(opc);
      ac = model_alu_ctrl(c[1:0], fb);
      r  = model_alu(ac, a, c[7] ? im : b);
      @(posedge clk);
      exp_valid = v;
      if (v) begin
         exp_ctrl     = c;
         exp_alu_ctrl = ac;
         exp_result   = r;
         exp_zero     = (r == 0);
      end
      #1;
      compare_all(tag);
      $display("txn %-10s v=%0d opc=%b fb=%b a=%h b=%h imm=%h -> ov=%0d res=%h z=%0d ctrl=%b ac=%b",
               tag, v, opc, fb, a, b, im, out_valid, result, zero,
               {alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op}, alu_ctrl);
   endtask

   task automatic model_reset();
      exp_valid    = 1'b0;
      exp_result   = '0;
      exp_zero     = 1'b0;
      exp_ctrl     = '0;
      exp_alu_ctrl = '0;
   endtask

   logic [15:0] sweep_res [4];
   logic [3:0]  sweep_fb  [4];
   logic [3:0]  sweep_ac  [4];
   logic [6:0]  rand_opc;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct_bits = '0;
      op_a = '0; op_b = '0; imm = '0;
      model_reset();
      #3;
      compare_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // R-type sweep with constants from the test plan.
      sweep_fb  = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};
      sweep_res = '{16'h0003, 16'hFFFF, 16'h0000, 16'h0003};
      sweep_ac  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
      for (int i = 0; i < 4; i++) begin
         step("rsweep", 1'b1, 7'b0110011, sweep_fb[i], 16'h0001, 16'h0002, 16'h0000);
         check_val("rsweep.const_res", 32'(result),   32'(sweep_res[i]));
         check_val("rsweep.const_ac",  32'(alu_ctrl), 32'(sweep_ac[i]));
         check_val("rsweep.const_z",   32'(zero),     32'(sweep_res[i] == 16'h0));
      end

      step("load",  1'b1, 7'b0000011, 4'b0000, 16'h0100, 16'h7777, 16'h0010);
      check_val("load.const_res", 32'(result), 32'h0110);
      step("store", 1'b1, 7'b0100011, 4'b0000, 16'h0100, 16'h7777, 16'h0010);
      check_val("store.const_res", 32'(result), 32'h0110);
      check_val("store.const_mw",  32'({mem_write, reg_write}), 32'b10);

      step("br_eq", 1'b1, 7'b1100011, 4'b0000, 16'h1234, 16'h1234, 16'h0ABC);
      check_val("br_eq.const_z", 32'({zero, branch, result}), {15'b0, 1'b1, 1'b1, 16'h0000});
      step("br_ne", 1'b1, 7'b1100011, 4'b0000, 16'h1234, 16'h1235, 16'h0ABC);
      check_val("br_ne.const_res", 32'({zero, result}), {15'b0, 1'b0, 16'hFFFF});

      // Valid gating 1-0-1; outputs hold through the gap.
      step("gate1", 1'b1, 7'b0110011, 4'b0000, 16'hFFFF, 16'h0001, 16'h0000);
      check_val("ovf.const", 32'({zero, result}), {15'b0, 1'b1, 16'h0000});
      step("gate0", 1'b0, 7'b0000011, 4'b0111, 16'h5555, 16'h3333, 16'h1111);
      step("gate1b", 1'b1, 7'b0110011, 4'b0110, 16'h00F0, 16'h0F00, 16'h0000);

      step("illegal", 1'b1, 7'b1111111, 4'b1000, 16'h0200, 16'h0022, 16'h9999);
      check_val("illegal.const_res", 32'(result), 32'h0222);
      step("rt_0101", 1'b1, 7'b0110011, 4'b0101, 16'h0004, 16'h0005, 16'h0000);
      check_val("rt_0101.const_ac", 32'(alu_ctrl), 32'b0010);

      // Asynchronous reset mid-cycle with nonzero outputs.
      step("pre_rst", 1'b1, 7'b0000011, 4'b0000, 16'h1000, 16'h0000, 16'h0234);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized operations.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 4))
            0: rand_opc = 7'b0110011;
            1: rand_opc = 7'b0000011;
            2: rand_opc = 7'b0100011;
            3: rand_opc = 7'b1100011;
            default: rand_opc = 7'($urandom);
         endcase
         step("rand", ($urandom_range(0, 3) != 0), rand_opc, 4'($urandom),
              16'($urandom), ($urandom_range(0, 7) == 0) ? op_a : 16'($urandom), 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
